// File: rtl/text_console_if.sv
// Command and framebuffer bundle for text_console_ctrl.
// Command side: cmd_valid/cmd_ready handshake with a 2-bit opcode and 16-bit payload.
// Framebuffer side: registered single-port write (fb_we, fb_waddr, fb_wdata).
// Status side: cursor position and busy flag.
// The modport named master is the command issuer / framebuffer consumer.
// The modport named slave is the console controller.
interface text_console_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_data;
    logic        fb_we;
    logic [11:0] fb_waddr;
    logic [15:0] fb_wdata;
    logic [6:0]  cur_col;
    logic [4:0]  cur_row;
    logic        busy;

    modport master (
        output cmd_valid, cmd_op, cmd_data,
        input  cmd_ready, fb_we, fb_waddr, fb_wdata, cur_col, cur_row, busy
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data,
        output cmd_ready, fb_we, fb_waddr, fb_wdata, cur_col, cur_row, busy
    );
endinterface

// File: rtl/text_console_ctrl.sv
// Text console controller: turns PUTC / SETATTR / SETCUR / CLEAR commands
// into framebuffer cell writes of {attribute, ascii}.
// Ports:
//   clk  - single clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - text_console_if.slave: command handshake, framebuffer write port,
//          cursor position and busy status
// A row advance (newline or wrap past the last column) blanks the new row;
// CLEAR blanks the whole screen. Both run one cell per cycle with cmd_ready low.
module text_console_ctrl #(
    parameter int         COLS       = 80,
    parameter int         ROWS       = 30,
    parameter logic [7:0] BLANK_CHAR = 8'h20
) (
    input logic           clk,
    input logic           rst,
    text_console_if.slave bus
);
    localparam int          CELLS      = COLS * ROWS;
    localparam logic [1:0]  OP_PUTC    = 2'b00;
    localparam logic [1:0]  OP_SETATTR = 2'b01;
    localparam logic [1:0]  OP_SETCUR  = 2'b10;
    localparam logic [6:0]  LAST_COL   = 7'(COLS - 1);
    localparam logic [4:0]  LAST_ROW   = 5'(ROWS - 1);
    localparam logic [11:0] LAST_CELL  = 12'(CELLS - 1);
    localparam logic [11:0] ROW_SPAN   = 12'(COLS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROWCLR = 2'd1,
        SCRCLR = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [6:0]  col;
    logic [4:0]  row;
    logic [7:0]  attr;
    logic        fb_we;
    logic [11:0] fb_waddr;
    logic [15:0] fb_wdata;
    logic [11:0] clr_addr;
    logic [11:0] clr_last;
    logic        clr_done;

    logic        accept;
    logic [7:0]  ascii;
    logic        is_lf;
    logic        is_cr;
    logic        row_adv;
    logic [4:0]  row_inc;
    logic [11:0] row_inc_base;

    function automatic logic [11:0] cell_addr(input logic [4:0] r, input logic [6:0] c);
        return 12'(r) * 12'(COLS) + 12'(c);
    endfunction

    assign bus.cmd_ready = (state == IDLE) && !rst;
    assign bus.busy      = (state != IDLE);
    assign bus.fb_we     = fb_we;
    assign bus.fb_waddr  = fb_waddr;
    assign bus.fb_wdata  = fb_wdata;
    assign bus.cur_col   = col;
    assign bus.cur_row   = row;

    assign accept = bus.cmd_valid && bus.cmd_ready;
    assign ascii  = bus.cmd_data[7:0];
    assign is_lf  = (ascii == 8'h0A);
    assign is_cr  = (ascii == 8'h0D);

    // A PUTC moves to the next row on newline, or when a printable character
    // lands in the last column.
    assign row_adv      = accept && (bus.cmd_op == OP_PUTC) &&
                          (is_lf || (!is_cr && (col == LAST_COL)));
    assign row_inc      = (row == LAST_ROW) ? 5'd0 : row + 5'd1;
    assign row_inc_base = cell_addr(row_inc, 7'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (row_adv) begin
                    state_nxt = ROWCLR;
                end else if (accept && (bus.cmd_op == 2'b11)) begin
                    state_nxt = SCRCLR;
                end
            end
            ROWCLR, SCRCLR: begin
                // clr_done is set by the edge that issued the final write, so
                // the busy window covers that write's output cycle.
                if (clr_done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fb_we    <= 1'b0;
            fb_waddr <= 12'd0;
            fb_wdata <= 16'd0;
            col      <= 7'd0;
            row      <= 5'd0;
            attr     <= 8'h07;
            clr_done <= 1'b1;
        end else begin
            fb_we <= 1'b0;
            if (state == IDLE) begin
                if (accept) begin
                    case (bus.cmd_op)
                        OP_PUTC: begin
                            if (is_lf || is_cr) begin
                                col <= 7'd0;
                            end else begin
                                fb_we    <= 1'b1;
                                fb_waddr <= cell_addr(row, col);
                                fb_wdata <= {attr, ascii};
                                col      <= (col == LAST_COL) ? 7'd0 : col + 7'd1;
                            end
                            if (row_adv) begin
                                row      <= row_inc;
                                clr_addr <= row_inc_base;
                                clr_last <= row_inc_base + ROW_SPAN;
                                clr_done <= 1'b0;
                            end
                        end
                        OP_SETATTR: begin
                            attr <= bus.cmd_data[15:8];
                        end
                        OP_SETCUR: begin
                            col <= (bus.cmd_data[6:0]  > LAST_COL) ? LAST_COL : bus.cmd_data[6:0];
                            row <= (bus.cmd_data[12:8] > LAST_ROW) ? LAST_ROW : bus.cmd_data[12:8];
                        end
                        default: begin
                            // CLEAR: cell 0 is written on the accepting edge, the
                            // remaining cells follow from the counter.
                            col      <= 7'd0;
                            row      <= 5'd0;
                            fb_we    <= 1'b1;
                            fb_waddr <= 12'd0;
                            fb_wdata <= {attr, BLANK_CHAR};
                            clr_addr <= 12'd1;
                            clr_last <= LAST_CELL;
                            clr_done <= (LAST_CELL == 12'd0);
                        end
                    endcase
                end
            end else if (!clr_done) begin
                fb_we    <= 1'b1;
                fb_waddr <= clr_addr;
                fb_wdata <= {attr, BLANK_CHAR};
                // Counter holds at the last cell instead of wrapping.
                if (clr_addr == clr_last) begin
                    clr_done <= 1'b1;
                end else begin
                    clr_addr <= clr_addr + 12'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_text_console_ctrl.sv
module tb_text_console_ctrl;
    localparam int COLS  = 80;
    localparam int ROWS  = 30;
    localparam int CELLS = COLS * ROWS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    text_console_if bus ();

    text_console_ctrl #(.COLS(COLS), .ROWS(ROWS), .BLANK_CHAR(8'h20)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    int          log_cyc[$];
    logic [11:0] log_addr[$];
    logic [15:0] log_data[$];
    logic [15:0] dut_mem [CELLS];
    logic [15:0] ref_mem [CELLS];

    always @(negedge clk) begin
        if (bus.fb_we === 1'b1) begin
            log_cyc.push_back(cyc);
            log_addr.push_back(bus.fb_waddr);
            log_data.push_back(bus.fb_wdata);
            if (bus.fb_waddr < 12'(CELLS)) dut_mem[bus.fb_waddr] = bus.fb_wdata;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] cur_data(input int c, input int r);
        return {3'b000, 5'(r), 1'b0, 7'(c)};
    endfunction

    task automatic clear_log();
        log_cyc.delete();
        log_addr.delete();
        log_data.delete();
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            if (bus.cmd_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Returns at the negedge right after the accepting edge; acc is that edge's count.
    task automatic send(input logic [1:0] op, input logic [15:0] d, output int acc, output bit ok);
        wait_ready(ok);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = d;
        @(negedge clk);
        acc = cyc;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        int acc;
        bit ok, ok2;
        send(2'b10, cur_data(10, 3), acc, ok);
        send(2'b00, 16'h0041, acc, ok2);
        total++;
        if (!(ok && ok2) || bus.fb_we !== 1'b1 || bus.fb_waddr !== 12'd250 || bus.fb_wdata !== 16'h0741) begin
            bad++;
            $display("FAIL pre_reset_write: we=%b addr=%0d data=%h, want we=1 addr=250 data=0741",
                     bus.fb_we, bus.fb_waddr, bus.fb_wdata);
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (bus.fb_we !== 1'b0 || bus.fb_waddr !== 12'd0 || bus.fb_wdata !== 16'd0 ||
            bus.cur_col !== 7'd0 || bus.cur_row !== 5'd0 || bus.busy !== 1'b0 || bus.cmd_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_values: we=%b addr=%0d data=%h col=%0d row=%0d busy=%b rdy=%b, want all zero",
                     bus.fb_we, bus.fb_waddr, bus.fb_wdata, bus.cur_col, bus.cur_row, bus.busy, bus.cmd_ready);
        end
        rst = 1'b0;
        #1;
        total++;
        if (bus.cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ready: got %b want 1", bus.cmd_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_putc();
        int acc;
        bit ok;
        clear_log();
        send(2'b00, 16'h0041, acc, ok);
        total++;
        if (!ok || bus.cmd_ready !== 1'b1 || bus.fb_we !== 1'b1) begin
            bad++;
            $display("FAIL putc_cycle: ok=%b rdy=%b we=%b, want 1 1 1", ok, bus.cmd_ready, bus.fb_we);
        end
        repeat (3) @(negedge clk);
        total++;
        if (log_addr.size() != 1 || log_addr[0] !== 12'd0 || log_data[0] !== 16'h0741 || log_cyc[0] != acc) begin
            bad++;
            $display("FAIL putc_write: n=%0d, want one write addr 0 data 0741", log_addr.size());
        end
        total++;
        if (bus.cur_col !== 7'd1 || bus.cur_row !== 5'd0) begin
            bad++;
            $display("FAIL putc_cursor: got (%0d,%0d) want (1,0)", bus.cur_col, bus.cur_row);
        end
    endtask

    task automatic test_cr();
        int acc;
        bit ok, ok2;
        send(2'b10, cur_data(7, 4), acc, ok);
        clear_log();
        send(2'b00, 16'h000D, acc, ok2);
        total++;
        if (!(ok && ok2) || bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL cr_stays_idle: rdy=%b busy=%b want 1 0", bus.cmd_ready, bus.busy);
        end
        repeat (3) @(negedge clk);
        total++;
        if (log_addr.size() != 0 || bus.cur_col !== 7'd0 || bus.cur_row !== 5'd4) begin
            bad++;
            $display("FAIL cr_effect: writes=%0d cursor=(%0d,%0d) want 0 writes (0,4)",
                     log_addr.size(), bus.cur_col, bus.cur_row);
        end
    endtask

    task automatic test_wrap();
        int acc, errs;
        bit ok, ok2;
        send(2'b10, cur_data(79, 0), acc, ok);
        clear_log();
        send(2'b00, 16'h0042, acc, ok2);
        errs = 0;
        // Hold a command on the bus during the clear; it must be ignored.
        for (int k = 0; k <= 80; k++) begin
            if (bus.cmd_ready !== 1'b0 || bus.busy !== 1'b1) errs++;
            bus.cmd_valid = (k >= 1 && k <= 40);
            bus.cmd_op    = 2'b00;
            bus.cmd_data  = 16'h0051;
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        total++;
        if (!(ok && ok2) || errs != 0 || bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL wrap_busy_window: bad cycles=%0d end rdy=%b busy=%b, want 0 1 0",
                     errs, bus.cmd_ready, bus.busy);
        end
        repeat (2) @(negedge clk);
        errs = 0;
        if (log_addr.size() != 81) errs++;
        else begin
            if (log_addr[0] !== 12'd79 || log_data[0] !== 16'h0742 || log_cyc[0] != acc) errs++;
            for (int i = 1; i <= 80; i++)
                if (log_addr[i] !== 12'(79 + i) || log_data[i] !== 16'h0720 || log_cyc[i] != acc + i) errs++;
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL wrap_writes: n=%0d errors=%0d, want 81 writes 79..159", log_addr.size(), errs);
        end
        total++;
        if (bus.cur_col !== 7'd0 || bus.cur_row !== 5'd1) begin
            bad++;
            $display("FAIL wrap_cursor: got (%0d,%0d) want (0,1)", bus.cur_col, bus.cur_row);
        end
    endtask

    task automatic test_newline();
        int acc, errs;
        bit ok, ok2, ok3;
        send(2'b10, cur_data(5, 29), acc, ok);
        clear_log();
        send(2'b00, 16'h000A, acc, ok2);
        wait_ready(ok3);
        total++;
        if (!(ok && ok2 && ok3) || cyc != acc + 81) begin
            bad++;
            $display("FAIL newline_ready: ready at edge %0d want %0d", cyc, acc + 81);
        end
        repeat (2) @(negedge clk);
        errs = 0;
        if (log_addr.size() != 80) errs++;
        else
            for (int i = 0; i < 80; i++)
                if (log_addr[i] !== 12'(i) || log_data[i] !== 16'h0720 || log_cyc[i] != acc + 1 + i) errs++;
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL newline_writes: n=%0d errors=%0d, want 80 writes 0..79", log_addr.size(), errs);
        end
        total++;
        if (bus.cur_col !== 7'd0 || bus.cur_row !== 5'd0) begin
            bad++;
            $display("FAIL newline_cursor: got (%0d,%0d) want (0,0)", bus.cur_col, bus.cur_row);
        end
    endtask

    task automatic test_clamp();
        int acc;
        bit ok, ok2;
        clear_log();
        send(2'b10, cur_data(100, 31), acc, ok);
        @(negedge clk);
        total++;
        if (!ok || bus.cur_col !== 7'd79 || bus.cur_row !== 5'd29) begin
            bad++;
            $display("FAIL clamp_max: got (%0d,%0d) want (79,29)", bus.cur_col, bus.cur_row);
        end
        send(2'b10, cur_data(80, 30), acc, ok2);
        @(negedge clk);
        total++;
        if (!ok2 || bus.cur_col !== 7'd79 || bus.cur_row !== 5'd29 || log_addr.size() != 0) begin
            bad++;
            $display("FAIL clamp_edge: got (%0d,%0d) writes=%0d want (79,29) 0",
                     bus.cur_col, bus.cur_row, log_addr.size());
        end
    endtask

    task automatic test_clear();
        int acc, errs;
        bit ok, ok2;
        send(2'b01, 16'h1F00, acc, ok);
        clear_log();
        send(2'b11, 16'h0000, acc, ok2);
        total++;
        if (!(ok && ok2) || bus.cur_col !== 7'd0 || bus.cur_row !== 5'd0) begin
            bad++;
            $display("FAIL clear_cursor: got (%0d,%0d) want (0,0)", bus.cur_col, bus.cur_row);
        end
        errs = 0;
        for (int k = 0; k < CELLS; k++) begin
            if (bus.cmd_ready !== 1'b0) errs++;
            @(negedge clk);
        end
        total++;
        if (errs != 0 || bus.cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL clear_ready_window: ready-high cycles=%0d end rdy=%b, want 0 and 1", errs, bus.cmd_ready);
        end
        repeat (2) @(negedge clk);
        errs = 0;
        if (log_addr.size() != CELLS) errs++;
        else
            for (int i = 0; i < CELLS; i++)
                if (log_addr[i] !== 12'(i) || log_data[i] !== 16'h1F20 || log_cyc[i] != acc + i) errs++;
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL clear_writes: n=%0d errors=%0d, want 2400 writes data 1F20", log_addr.size(), errs);
        end
    endtask

    task automatic test_reset_abort();
        int acc, rcyc, late;
        bit ok, found, ok2;
        send(2'b11, 16'h0000, acc, ok);
        found = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if (bus.fb_we === 1'b1 && bus.fb_waddr === 12'd1000) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        rst  = 1'b1;
        rcyc = cyc;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (!(ok && found) || bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_release: found=%b rdy=%b busy=%b want 1 1 0", found, bus.cmd_ready, bus.busy);
        end
        repeat (5) @(negedge clk);
        late = 0;
        foreach (log_cyc[i]) if (log_cyc[i] > rcyc) late++;
        total++;
        if (late != 0 || bus.cur_col !== 7'd0 || bus.cur_row !== 5'd0) begin
            bad++;
            $display("FAIL abort_quiet: late writes=%0d cursor=(%0d,%0d) want 0 (0,0)",
                     late, bus.cur_col, bus.cur_row);
        end
        clear_log();
        send(2'b00, 16'h005A, acc, ok2);
        total++;
        if (!ok2 || bus.fb_we !== 1'b1 || bus.fb_waddr !== 12'd0 || bus.fb_wdata !== 16'h075A) begin
            bad++;
            $display("FAIL abort_attr: addr=%0d data=%h want 0 075A", bus.fb_waddr, bus.fb_wdata);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        int  m_col, m_row, acc, n_exp, clears, cur_errs, mem_errs;
        int  c, r, rnd;
        logic [7:0]  m_attr, ch;
        logic [1:0]  op;
        logic [15:0] d;
        bit ok, ok2, all_ok;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        clear_log();
        for (int i = 0; i < CELLS; i++) begin
            dut_mem[i] = 16'h0000;
            ref_mem[i] = 16'h0000;
        end
        m_col = 0; m_row = 0; m_attr = 8'h07; n_exp = 0; clears = 0;
        cur_errs = 0; all_ok = 1'b1;
        for (int n = 0; n < 150; n++) begin
            rnd = $urandom_range(0, 99);
            d   = 16'($urandom);
            if (rnd < 70) begin
                op = 2'b00;
                r  = $urandom_range(0, 99);
                ch = (r < 10) ? 8'h0A : (r < 15) ? 8'h0D : 8'($urandom_range(32, 126));
                d  = {8'($urandom), ch};
            end else if (rnd < 80) op = 2'b01;
            else if (rnd < 98 || clears >= 2) op = 2'b10;
            else begin op = 2'b11; clears++; end

            case (op)
                2'b00: begin
                    ch = d[7:0];
                    if (ch == 8'h0D) m_col = 0;
                    else begin
                        if (ch != 8'h0A) begin
                            ref_mem[m_row * COLS + m_col] = {m_attr, ch};
                            n_exp++;
                        end
                        if (ch == 8'h0A || m_col == COLS - 1) begin
                            m_col = 0;
                            m_row = (m_row + 1) % ROWS;
                            for (int i = 0; i < COLS; i++) ref_mem[m_row * COLS + i] = {m_attr, 8'h20};
                            n_exp += COLS;
                        end else m_col++;
                    end
                end
                2'b01: m_attr = d[15:8];
                2'b10: begin
                    c = d[6:0];
                    r = d[12:8];
                    m_col = (c >= COLS) ? COLS - 1 : c;
                    m_row = (r >= ROWS) ? ROWS - 1 : r;
                end
                default: begin
                    m_col = 0;
                    m_row = 0;
                    for (int i = 0; i < CELLS; i++) ref_mem[i] = {m_attr, 8'h20};
                    n_exp += CELLS;
                end
            endcase

            send(op, d, acc, ok);
            wait_ready(ok2);
            if (!(ok && ok2)) all_ok = 1'b0;
            if (bus.cur_col !== 7'(m_col) || bus.cur_row !== 5'(m_row)) begin
                if (cur_errs == 0)
                    $display("FAIL rand_cursor: cmd %0d got (%0d,%0d) want (%0d,%0d)",
                             n, bus.cur_col, bus.cur_row, m_col, m_row);
                cur_errs++;
            end
        end
        repeat (3) @(negedge clk);
        total++;
        if (!all_ok || cur_errs != 0) begin
            bad++;
            $display("FAIL rand_cursor_total: handshake ok=%b cursor errors=%0d want 1 0", all_ok, cur_errs);
        end
        total++;
        if (log_addr.size() != n_exp) begin
            bad++;
            $display("FAIL rand_write_count: got %0d want %0d", log_addr.size(), n_exp);
        end
        mem_errs = 0;
        for (int i = 0; i < CELLS; i++) begin
            if (dut_mem[i] !== ref_mem[i]) begin
                if (mem_errs == 0)
                    $display("FAIL rand_cell: addr %0d got %h want %h", i, dut_mem[i], ref_mem[i]);
                mem_errs++;
            end
        end
        total++;
        if (mem_errs != 0) begin
            bad++;
            $display("FAIL rand_framebuffer: %0d cells differ, want 0", mem_errs);
        end
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_data  = 16'h0000;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_putc();
        test_cr();
        test_wrap();
        test_newline();
        test_clamp();
        test_clear();
        test_reset_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
